// File: rtl/aes_pkg.sv
// Shared AES-128 constants and helpers: forward S-box, GF(2^8) xtime,
// column-major state indexing and the MixColumns column transform.
package aes_pkg;

  localparam int STATE_W = 128;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of the state lives at the MSB end for k = 0 (column-major).
  function automatic logic [3:0] stateIdx(input int r, input int c);
    return 4'(4 * c + r);
  endfunction

  function automatic logic [7:0] getByte(input logic [STATE_W-1:0] s, input int k);
    return s[127 - 8 * k -: 8];
  endfunction

  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: purely combinational 8-bit table lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/do_round.sv
// One AES-128 middle round (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// computed combinationally and captured in a single output register.
module do_round
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] data_out
);

  logic [7:0]   w_sub   [16];
  logic [7:0]   w_shift [16];
  logic [127:0] w_mixed;
  logic [127:0] w_roundVal;
  logic [127:0] r_dataOut;

  for (genvar k = 0; k < 16; k++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte(getByte(data_in, k)),
      .o_byte(w_sub[k])
    );
  end

  // Row r of column c takes the byte from column (c + r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_shift[stateIdx(r, c)] = w_sub[stateIdx(r, (c + r) % 4)];
    end
    assign w_mixed[127 - 32 * c -: 32] = mixColumn({w_shift[stateIdx(0, c)],
                                                    w_shift[stateIdx(1, c)],
                                                    w_shift[stateIdx(2, c)],
                                                    w_shift[stateIdx(3, c)]});
  end

  assign w_roundVal = w_mixed ^ key_in;

  always_ff @(posedge clk) begin
    if (!rst_n) r_dataOut <= '0;
    else        r_dataOut <= w_roundVal;
  end

  assign data_out = r_dataOut;

endmodule

// File: tb/tb_do_round.sv
// Directed-vector bench for do_round: reset behaviour, known AES round
// results, back-to-back throughput and a mid-stream reset.
module tb_do_round;

  logic         clk;
  logic         rst_n;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] data_out;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ZERO_OUT = 128'h63636363636363636363636363636363;
  localparam logic [127:0] PAT      = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] PAT_OUT  = 128'heef6fd4a8e19b997eef6fd4a8e19b997;
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] ONES     = {128{1'b1}};
  localparam logic [127:0] KEYFF_OUT = 128'h9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c;
  localparam logic [127:0] ALLFF_OUT = 128'h16161616161616161616161616161616;
  localparam logic [127:0] ALL01    = 128'h01010101010101010101010101010101;
  localparam logic [127:0] ALL01_OUT = 128'h7c7c7c7c7c7c7c7c7c7c7c7c7c7c7c7c;

  do_round dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .key_in(key_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [127:0] din, input logic [127:0] key);
    data_in = din;
    key_in  = key;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] expected);
    checks++;
    assert (data_out === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, data_out, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(FIPS_IN, FIPS_KEY);

    // Held in reset for three edges with live inputs.
    tick();
    checkOutput("reset_edge1", '0);
    applyStimulus(PAT, PAT);
    tick();
    checkOutput("reset_edge2", '0);
    applyStimulus(FIPS_IN, FIPS_KEY);
    tick();
    checkOutput("reset_edge3", '0);

    rst_n = 1'b1;
    tick();
    checkOutput("first_after_reset", FIPS_OUT);

    applyStimulus('0, '0);
    tick();
    checkOutput("zero_vector", ZERO_OUT);

    applyStimulus(PAT, PAT);
    tick();
    checkOutput("pattern_vector", PAT_OUT);

    applyStimulus(FIPS_IN, FIPS_KEY);
    tick();
    checkOutput("fips_round1", FIPS_OUT);

    applyStimulus('0, ONES);
    tick();
    checkOutput("key_all_ones", KEYFF_OUT);

    applyStimulus(ONES, '0);
    tick();
    checkOutput("data_all_ones", ALLFF_OUT);

    applyStimulus(ALL01, '0);
    tick();
    checkOutput("data_all_01", ALL01_OUT);

    // Back-to-back: each result must track its own input exactly one edge later.
    applyStimulus('0, '0);
    tick();
    checkOutput("b2b_zero", ZERO_OUT);
    applyStimulus(PAT, PAT);
    tick();
    checkOutput("b2b_pattern", PAT_OUT);
    applyStimulus(FIPS_IN, FIPS_KEY);
    tick();
    checkOutput("b2b_fips", FIPS_OUT);

    // Mid-stream reset discards the in-flight round.
    applyStimulus(PAT, PAT);
    rst_n = 1'b0;
    tick();
    checkOutput("midstream_reset", '0);
    rst_n = 1'b1;
    applyStimulus('0, ONES);
    tick();
    checkOutput("resume_key_ones", KEYFF_OUT);
    applyStimulus(FIPS_IN, FIPS_KEY);
    tick();
    checkOutput("resume_fips", FIPS_OUT);

    $display("[TB] directed sequence complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
